plic_target_arbiter: RTL and testbench
======================================

// Module: plic_target_arbiter
// PURPOSE
//  Target-side end of the PLIC claim/complete path. Consumes per-source pending bits from the gateway.
//  Per target, finds the highest-priority enabled pending source with a sequential sweep.
//  Raises the target's external interrupt line and returns the claimed ID to the gateway.
// PARAMETERS
//  PLIC_SOURCE_COUNT    16  number of interrupt sources (IDs 1..N; ID 0 = none)
//  PLIC_TARGET_COUNT    2   number of targets (hart contexts)
//  PLIC_PRIORITY_WIDTH  3   priority field width; priority 0 = never interrupts
//  PLIC_SOURCE_WIDTH    5   ID width, $clog2(PLIC_SOURCE_COUNT+1)
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous reset, active-high
//  irq_pending_i  in   SRC         pending bits from gateway (bit i = ID i+1)
//  priority_i     in   SRC*PRIO_W  per-source priority
//  enable_i       in   TGT*SRC     per-target source enables
//  threshold_i    in   TGT*PRIO_W  per-target priority threshold
//  claim_req_i    in   TGT         claim read strobe, one cycle, per target
//  claim_idx_o    out  TGT*SRC_W   claimed ID; same cycle as claim_req_i; to gateway and regs
//  irq_target_o   out  TGT         external interrupt request per target
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (rst).
//  Reset: ptr=1; running and result {id,prio}=0 for every target.
//   irq_target_o=0 and claim_idx_o=0 from the first cycle after reset.
//   rst asserted mid-sweep aborts the sweep; the next sweep starts at ptr=1.
//  Sweep: ptr counts 1..SRC and wraps to 1. The counter is shared; each target has its own compare slice.
//   - Each cycle, source ptr is a candidate for target t when pending[ptr-1] & enable[t][ptr-1] & prio!=0.
//   - A candidate replaces running best only if prio > running_prio (strict). Lowest ID wins ties.
//   - In the ptr==SRC cycle, the final running value (including ptr itself) commits to result[t].
//     Running is then cleared.
//   - Sweep latency is SRC cycles. A newly pending source is visible in result within 2*SRC cycles worst case.
//  irq_target_o[t] = (result_id[t]!=0) & (result_prio[t] > threshold_i[t]), combinational from registers.
//   A threshold change takes effect in the same cycle.
//   A pending bit that drops is masked from irq_target_o only after the next commit.
//  Claim (combinational in the claim_req cycle):
//   - claim_idx_o[t] = result_id[t] when claim_req_i[t], result_id!=0, pending[result_id-1] is still 1,
//     and result_prio > threshold. Otherwise 0.
//   - Simultaneous claims of the same ID: the lowest-index target gets the ID; the others get 0.
//   - claim_idx_o[t]=0 whenever claim_req_i[t]=0.
//  Claim side effects (registered): for every ID X granted this cycle:
//   - every target's result with id==X is cleared to 0;
//   - every running best with id==X is cleared to 0;
//   - a commit of X in the same cycle is suppressed (result written as 0).
//   This prevents a stale re-claim before the gateway's pending clear propagates.
//  Complete is not handled here; it goes regs -> gateway directly.
//  All arithmetic is unsigned. The ptr-1 index never underflows because ptr>=1.
// STRUCTURE
//  plic_defs package: PLIC_* constants and typedef type_target_best_s {id, prio}.
//  One sub-module, plic_target_slice, instantiated TGT times:
//   running/result registers, candidate compare, claim-invalidate logic.
//  The top level holds the shared ptr counter, cross-target claim tie-break and output assembly.
// TESTING
//  1. rst=1 then 0; all pending=0 -> irq_target_o=0, claim returns 0 for 2*SRC cycles.
//  2. T0: ID3 prio2, ID7 prio5, both enabled, thr=1.
//     -> irq_target_o[0]=1 within 2*SRC cycles; claim returns 7.
//     Pending7 cleared -> next commit gives 3; claim returns 3.
//  3. ID4 and ID9 both prio 4 -> claim returns 4 (tie to lower ID).
//     thr raised to 4 -> irq_target_o[0]=0 same cycle; claim returns 0.
//  4. ID5 enabled for T0 and T1, both claim same cycle -> T0 gets 5, T1 gets 0.
//     Neither result holds 5 afterwards.
//  5. Claim issued in the ptr==SRC commit cycle for the same ID -> claim granted once.
//     Result cleared; a second claim the next cycle returns 0.
//  6. rst pulsed mid-sweep (ptr=8) with pending sources -> outputs 0 next cycle.
//     The sweep restarts at ptr=1; irq reappears after SRC cycles.

Source files
------------

// File: rtl/plic_target_arbiter_pkg.sv
// rtl/plic_target_arbiter_pkg.sv - PLIC target-arbiter constants, best-candidate type and ID helper
package plic_defs;

   localparam int PLIC_SOURCE_COUNT   = 16;
   localparam int PLIC_TARGET_COUNT   = 2;
   localparam int PLIC_PRIORITY_WIDTH = 3;
   localparam int PLIC_SOURCE_WIDTH   = $clog2(PLIC_SOURCE_COUNT + 1);

   typedef struct packed {
      logic [PLIC_SOURCE_WIDTH-1:0]   id;
      logic [PLIC_PRIORITY_WIDTH-1:0] prio;
   } type_target_best_s;

   // True when id names a source whose bit is set in mask; ID 0 never matches.
   function automatic logic id_in_mask(input logic [PLIC_SOURCE_COUNT-1:0] mask,
                                       input logic [PLIC_SOURCE_WIDTH-1:0] id);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < PLIC_SOURCE_COUNT; i++)
         if (mask[i] && (id == PLIC_SOURCE_WIDTH'(i + 1)))
            hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/plic_target_slice.sv
// rtl/plic_target_slice.sv - per-target running/result registers with claim invalidation
module plic_target_slice
   import plic_defs::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [PLIC_SOURCE_WIDTH-1:0]   ptr,
   input  logic                           cand_valid,
   input  logic [PLIC_PRIORITY_WIDTH-1:0] cand_prio,
   input  logic                           commit,
   input  logic [PLIC_SOURCE_COUNT-1:0]   kill,
   output type_target_best_s              result
);

   type_target_best_s running;
   type_target_best_s run_base;
   type_target_best_s run_next;
   type_target_best_s result_next;

   // A granted ID is dropped from running, from the candidate slot and from result alike,
   // so a commit in the grant cycle can never resurrect it.
   always_comb begin
      run_base = running;
      if (id_in_mask(kill, running.id))
         run_base = '0;

      run_next = run_base;
      if (cand_valid && !id_in_mask(kill, ptr) && (cand_prio > run_base.prio)) begin
         run_next.id   = ptr;
         run_next.prio = cand_prio;
      end

      result_next = result;
      if (id_in_mask(kill, result.id))
         result_next = '0;
      if (commit)
         result_next = run_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         running <= '0;
         result  <= '0;
      end else begin
         running <= commit ? '0 : run_next;
         result  <= result_next;
      end
   end

endmodule

// File: rtl/plic_target_arbiter.sv
// rtl/plic_target_arbiter.sv - shared sweep pointer, claim tie-break and output assembly
module plic_target_arbiter
   import plic_defs::*;
(
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [PLIC_SOURCE_COUNT-1:0]                      irq_pending_i,
   input  logic [PLIC_SOURCE_COUNT*PLIC_PRIORITY_WIDTH-1:0]  priority_i,
   input  logic [PLIC_TARGET_COUNT*PLIC_SOURCE_COUNT-1:0]    enable_i,
   input  logic [PLIC_TARGET_COUNT*PLIC_PRIORITY_WIDTH-1:0]  threshold_i,
   input  logic [PLIC_TARGET_COUNT-1:0]                      claim_req_i,
   output logic [PLIC_TARGET_COUNT*PLIC_SOURCE_WIDTH-1:0]    claim_idx_o,
   output logic [PLIC_TARGET_COUNT-1:0]                      irq_target_o
);

   localparam int SRC = PLIC_SOURCE_COUNT;
   localparam int TGT = PLIC_TARGET_COUNT;
   localparam int PW  = PLIC_PRIORITY_WIDTH;
   localparam int SW  = PLIC_SOURCE_WIDTH;

   localparam logic [SW-1:0] PTR_FIRST = SW'(1);
   localparam logic [SW-1:0] PTR_LAST  = SW'(SRC);

   logic [SW-1:0]     ptr;
   logic              commit;
   logic              sel_pending;
   logic [PW-1:0]     sel_prio;
   logic [TGT-1:0]    sel_enable;
   logic [TGT-1:0]    cand_valid;
   logic [TGT-1:0]    claim_ok;
   logic [TGT-1:0]    grant;
   logic [SRC-1:0]    kill;
   logic [PW-1:0]     thr [TGT];
   type_target_best_s result [TGT];

   assign commit = (ptr == PTR_LAST);

   always_ff @(posedge clk) begin
      if (rst || commit)
         ptr <= PTR_FIRST;
      else
         ptr <= ptr + SW'(1);
   end

   always_comb begin
      sel_pending = 1'b0;
      sel_prio    = '0;
      sel_enable  = '0;
      for (int i = 0; i < SRC; i++) begin
         if (ptr == SW'(i + 1)) begin
            sel_pending = irq_pending_i[i];
            sel_prio    = priority_i[i*PW +: PW];
            for (int t = 0; t < TGT; t++)
               sel_enable[t] = enable_i[t*SRC + i];
         end
      end
   end

   for (genvar t = 0; t < TGT; t++) begin : g_slice
      assign cand_valid[t] = sel_pending && sel_enable[t] && (sel_prio != '0);

      plic_target_slice u_slice (
         .clk        (clk),
         .rst        (rst),
         .ptr        (ptr),
         .cand_valid (cand_valid[t]),
         .cand_prio  (sel_prio),
         .commit     (commit),
         .kill       (kill),
         .result     (result[t])
      );
   end

   // Lowest-index target wins when several targets claim the same ID in one cycle.
   always_comb begin
      kill        = '0;
      claim_idx_o = '0;
      for (int t = 0; t < TGT; t++) begin
         thr[t]          = threshold_i[t*PW +: PW];
         irq_target_o[t] = (result[t].id != '0) && (result[t].prio > thr[t]);
         claim_ok[t]     = claim_req_i[t] && irq_target_o[t]
                           && id_in_mask(irq_pending_i, result[t].id);
      end
      for (int t = 0; t < TGT; t++) begin
         grant[t] = claim_ok[t];
         for (int u = 0; u < t; u++)
            if (claim_ok[u] && (result[u].id == result[t].id))
               grant[t] = 1'b0;
         if (grant[t]) begin
            claim_idx_o[t*SW +: SW] = result[t].id;
            for (int i = 0; i < SRC; i++)
               if (result[t].id == SW'(i + 1))
                  kill[i] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_plic_target_arbiter.sv
// tb/tb_plic_target_arbiter.sv - self-checking bench for plic_target_arbiter
module tb_plic_target_arbiter;

   localparam int SRC = 16;
   localparam int TGT = 2;
   localparam int PW  = 3;
   localparam int SW  = 5;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [SRC-1:0]     pending;
   logic [SRC*PW-1:0]  prio_v;
   logic [TGT*SRC-1:0] en_v;
   logic [TGT*PW-1:0]  thr_v;
   logic [TGT-1:0]     claim;
   logic [TGT*SW-1:0]  cidx;
   logic [TGT-1:0]     irq;

   int errors = 0;
   int checks = 0;
   int mptr   = 1;

   always #5 clk = ~clk;

   plic_target_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .irq_pending_i (pending),
      .priority_i    (prio_v),
      .enable_i      (en_v),
      .threshold_i   (thr_v),
      .claim_req_i   (claim),
      .claim_idx_o   (cidx),
      .irq_target_o  (irq)
   );

   // Slot = posedge+1 .. next posedge; mptr is the bench's own view of which source the sweep visits.
   task automatic tick();
      @(posedge clk);
      #1;
      mptr = (mptr == SRC) ? 1 : mptr + 1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      claim = '0;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      mptr = 1;
   endtask

   task automatic clear_cfg();
      pending = '0;
      prio_v  = '0;
      en_v    = '0;
      thr_v   = '0;
      claim   = '0;
   endtask

   task automatic set_src(input int t, input int id, input int p);
      prio_v[(id-1)*PW +: PW] = PW'(p);
      en_v[t*SRC + id - 1]    = 1'b1;
      pending[id-1]           = 1'b1;
   endtask

   function automatic int idx_of(input int t);
      return int'(cidx[t*SW +: SW]);
   endfunction

   function automatic int prio_of(input int id);
      return int'(prio_v[(id-1)*PW +: PW]);
   endfunction

   function automatic int thr_of(input int t);
      return int'(thr_v[t*PW +: PW]);
   endfunction

   task automatic wait_irq(input int t);
      int n = 0;
      while (!irq[t] && n < 2*SRC + 2) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      clear_cfg();
      do_reset();
      for (int n = 0; n < 2*SRC; n++) begin
         claim = '1;
         #1;
         checks++;
         if (irq !== '0) begin
            errors++;
            $display("FAIL reset_irq: cycle %0d irq=%b want 00", n, irq);
         end
         checks++;
         if (cidx !== '0) begin
            errors++;
            $display("FAIL reset_claim: cycle %0d claim_idx=%h want 0", n, cidx);
         end
         tick();
      end
      claim = '0;
   endtask

   task automatic test_claim_order();
      clear_cfg();
      do_reset();
      set_src(0, 3, 2);
      set_src(0, 7, 5);
      thr_v[0 +: PW] = 3'd1;
      wait_irq(0);
      checks++;
      if (irq[0] !== 1'b1) begin
         errors++;
         $display("FAIL order_irq: irq0=%b want 1", irq[0]);
      end
      claim[0] = 1'b1;
      #1;
      checks++;
      if (idx_of(0) !== 7) begin
         errors++;
         $display("FAIL order_claim7: got %0d want 7", idx_of(0));
      end
      tick();
      claim       = '0;
      pending[6]  = 1'b0;
      #1;
      checks++;
      if (irq[0] !== 1'b0) begin
         errors++;
         $display("FAIL order_cleared: irq0=%b want 0", irq[0]);
      end
      wait_irq(0);
      claim[0] = 1'b1;
      #1;
      checks++;
      if (idx_of(0) !== 3) begin
         errors++;
         $display("FAIL order_claim3: got %0d want 3", idx_of(0));
      end
      tick();
      claim = '0;
   endtask

   task automatic test_tie_threshold();
      clear_cfg();
      do_reset();
      set_src(0, 4, 4);
      set_src(0, 9, 4);
      thr_v[0 +: PW] = 3'd1;
      wait_irq(0);
      thr_v[0 +: PW] = 3'd4;
      #1;
      checks++;
      if (irq[0] !== 1'b0) begin
         errors++;
         $display("FAIL thr_mask: irq0=%b want 0", irq[0]);
      end
      claim[0] = 1'b1;
      #1;
      checks++;
      if (idx_of(0) !== 0) begin
         errors++;
         $display("FAIL thr_claim: got %0d want 0", idx_of(0));
      end
      thr_v[0 +: PW] = 3'd3;
      #1;
      checks++;
      if (idx_of(0) !== 4) begin
         errors++;
         $display("FAIL tie_low_id: got %0d want 4", idx_of(0));
      end
      tick();
      claim = '0;
   endtask

   task automatic test_dual_claim();
      clear_cfg();
      do_reset();
      set_src(0, 5, 3);
      set_src(1, 5, 3);
      wait_irq(0);
      wait_irq(1);
      claim = 2'b11;
      #1;
      checks++;
      if (idx_of(0) !== 5 || idx_of(1) !== 0) begin
         errors++;
         $display("FAIL dual_claim: got t0=%0d t1=%0d want 5 0", idx_of(0), idx_of(1));
      end
      tick();
      #1;
      checks++;
      if (irq !== 2'b00 || cidx !== '0) begin
         errors++;
         $display("FAIL dual_invalidate: irq=%b claim_idx=%h want 00 0", irq, cidx);
      end
      tick();
      claim   = '0;
      pending = '0;
   endtask

   task automatic test_commit_claim();
      clear_cfg();
      do_reset();
      set_src(0, 6, 3);
      while (mptr != SRC) tick();
      checks++;
      if (irq[0] !== 1'b0) begin
         errors++;
         $display("FAIL pre_commit: irq0=%b want 0", irq[0]);
      end
      tick();
      checks++;
      if (irq[0] !== 1'b1) begin
         errors++;
         $display("FAIL commit_latency: irq0=%b want 1", irq[0]);
      end
      while (mptr != SRC) tick();
      claim[0] = 1'b1;
      #1;
      checks++;
      if (idx_of(0) !== 6) begin
         errors++;
         $display("FAIL claim_at_commit: got %0d want 6", idx_of(0));
      end
      tick();
      #1;
      checks++;
      if (idx_of(0) !== 0 || irq[0] !== 1'b0) begin
         errors++;
         $display("FAIL reclaim_after_commit: got %0d irq0=%b want 0 0", idx_of(0), irq[0]);
      end
      tick();
      claim = '0;
   endtask

   task automatic test_mid_reset();
      clear_cfg();
      do_reset();
      set_src(0, 2, 7);
      set_src(1, 2, 7);
      while (mptr != SRC) tick();
      tick();
      checks++;
      if (irq !== 2'b11) begin
         errors++;
         $display("FAIL pre_reset_irq: irq=%b want 11", irq);
      end
      while (mptr != 8) tick();
      do_reset();
      claim = '1;
      #1;
      checks++;
      if (irq !== 2'b00 || cidx !== '0) begin
         errors++;
         $display("FAIL mid_reset: irq=%b claim_idx=%h want 00 0", irq, cidx);
      end
      claim = '0;
      while (mptr != SRC) tick();
      checks++;
      if (irq !== 2'b00) begin
         errors++;
         $display("FAIL restart_early: irq=%b want 00", irq);
      end
      tick();
      checks++;
      if (irq !== 2'b11) begin
         errors++;
         $display("FAIL restart_commit: irq=%b want 11", irq);
      end
   endtask

   // Reference: each sweep's result is the highest-priority recorded candidate, lowest ID on ties.
   task automatic test_random();
      bit rc [TGT][SRC+1];
      int rp [SRC+1];
      int eid [TGT];
      int ep  [TGT];
      int gid [TGT];
      bit ok  [TGT];
      bit exp_irq;
      bit got1;
      clear_cfg();
      do_reset();
      for (int t = 0; t < TGT; t++) begin
         eid[t] = 0;
         ep[t]  = 0;
      end
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 2) == 0)
            pending = pending & 16'($urandom);
         #1;
         for (int t = 0; t < TGT; t++) begin
            exp_irq = (eid[t] != 0) && (ep[t] > thr_of(t));
            checks++;
            if (irq[t] !== exp_irq) begin
               errors++;
               $display("FAIL rand_irq: iter %0d t%0d irq=%b want %b", it, t, irq[t], exp_irq);
            end
         end
         claim = TGT'($urandom);
         #1;
         for (int t = 0; t < TGT; t++)
            ok[t] = claim[t] && (eid[t] != 0) && (ep[t] > thr_of(t)) && pending[eid[t]-1];
         got1 = 1'b0;
         for (int t = 0; t < TGT; t++) begin
            gid[t] = ok[t] ? eid[t] : 0;
            for (int u = 0; u < t; u++)
               if (ok[u] && eid[u] == eid[t]) gid[t] = 0;
            if (gid[t] == 1) got1 = 1'b1;
            checks++;
            if (idx_of(t) !== gid[t]) begin
               errors++;
               $display("FAIL rand_claim: iter %0d t%0d got %0d want %0d", it, t, idx_of(t), gid[t]);
            end
         end
         for (int t = 0; t < TGT; t++)
            for (int u = 0; u < TGT; u++)
               if (gid[u] != 0 && eid[t] == gid[u]) begin
                  eid[t] = 0;
                  ep[t]  = 0;
               end
         rp[1] = prio_of(1);
         for (int t = 0; t < TGT; t++)
            rc[t][1] = pending[0] && en_v[t*SRC] && (rp[1] != 0) && !got1;
         tick();
         claim   = '0;
         pending = 16'($urandom);
         prio_v  = 48'({$urandom, $urandom});
         en_v    = 32'($urandom);
         for (int t = 0; t < TGT; t++)
            thr_v[t*PW +: PW] = PW'($urandom_range(0, 3));
         #1;
         for (int t = 0; t < TGT; t++) begin
            exp_irq = (eid[t] != 0) && (ep[t] > thr_of(t));
            checks++;
            if (irq[t] !== exp_irq) begin
               errors++;
               $display("FAIL rand_post_claim: iter %0d t%0d irq=%b want %b", it, t, irq[t], exp_irq);
            end
         end
         for (int k = 2; k <= SRC; k++) begin
            rp[k] = prio_of(k);
            for (int t = 0; t < TGT; t++)
               rc[t][k] = pending[k-1] && en_v[t*SRC + k - 1] && (rp[k] != 0);
            tick();
         end
         for (int t = 0; t < TGT; t++) begin
            eid[t] = 0;
            ep[t]  = 0;
            for (int k = 1; k <= SRC; k++)
               if (rc[t][k] && rp[k] > ep[t]) begin
                  eid[t] = k;
                  ep[t]  = rp[k];
               end
         end
      end
      claim = '0;
   endtask

   initial begin
      clear_cfg();
      test_reset();
      test_claim_order();
      test_tie_threshold();
      test_dual_claim();
      test_commit_claim();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
